tlul_host_arb2: RTL and testbench
=================================

# tlul_host_arb2

Two-host TL-UL arbiter that shares one downstream TL-UL device port between two hosts, such as the Ibex instruction and data adapters targeting a common memory. A-channel requests are forwarded combinationally under a round-robin, request-locking grant. A per-transaction host-ID FIFO routes D-channel responses back to the originating host, in order. It sits between the `ibex_to_tlul_host` adapters and a single device or crossbar port.

## Interface
- `MaxOutstanding`, default 2: max in-flight A transactions; ID FIFO depth; must be ≥1.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `tl_h0_i`  in  `tl_h2d_t`  host 0 request.
- `tl_h0_o`  out  `tl_d2h_t`  host 0 response.
- `tl_h1_i`  in  `tl_h2d_t`  host 1 request.
- `tl_h1_o`  out  `tl_d2h_t`  host 1 response.
- `tl_d_o`  out  `tl_h2d_t`  device request.
- `tl_d_i`  in  `tl_d2h_t`  device response.
- `arb_err_o`  out  1  sticky: D beat received with empty ID FIFO.

## Operation
- **Grant selection.**
  - If a lock is held, the locked host is selected.
  - Otherwise, with one host requesting (`a_valid`), that host is selected.
  - With both requesting, the host other than `last_grant_q` is selected.
- **A path.**
  - `tl_d_o` carries the selected host's A fields. `a_valid` is gated by `!fifo_full`.
  - Selected host `a_ready` = device `a_ready && !fifo_full`. The unselected host `a_ready` = 0.
  - `a_source` passes through unmodified.
  - `tl_d_o.d_ready` is driven from the routed host (see D path).
- **Lock.**
  - A lock is set when the selected `a_valid` is presented and the A handshake does not complete that cycle.
  - It clears on the handshake. This keeps the TL-UL rule that a presented request is stable until accepted.
- **Handshake.** On an A handshake: `last_grant_q` ← selected host, and the host ID is pushed into the FIFO.
- **D path.**
  - The FIFO head selects the target host. That host sees device `d_valid` and D fields; the other host sees `d_valid` = 0.
  - Device `d_ready` = target host `d_ready`.
  - On a D handshake the FIFO head is popped.
- **Ordering.** The downstream device is required to respond in request order; all devices on this bus do.
- **Empty FIFO with `d_valid`.** `d_ready` = 1 (beat dropped), no host sees it, `arb_err_o` ← 1.
- **Full / empty / wrap.**
  - `fifo_full` is derived from the registered count only. A pop in the same cycle does not allow a push while full.
  - Push and pop in the same cycle while not full: count unchanged.
  - Read and write pointers wrap modulo `MaxOutstanding`.
- **Reset mid-operation.** All state clears, including the lock, FIFO and `last_grant_q`. In-flight responses arriving after reset are treated as unexpected, so `arb_err_o` sets.

## Timing
- A and D paths are zero-latency combinational forwarding. State updates on the clock edge following a handshake.
- Reset values:
  - `last_grant_q` = 1, so host 0 wins the first contention.
  - lock = 0, FIFO count = 0, `arb_err_o` = 0.
  - Device `a_valid` = 0 unless a host requests; both host `d_valid` = 0.
- Throughput: one A handshake per cycle while not full. Under contention grants alternate every handshake.
- There is no combinational path from device `a_ready` to grant selection, except through the lock.

## Configuration
- `TLUL_HOST_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, host 1 (data) always wins contention. `last_grant_q` is still maintained but unused for selection.
  - Undefined: round-robin as described above.
  - Locking and FIFO behaviour are identical in both modes.

## Structure
- Package `tlul_host_arb_pkg`:
  - `host_id_e` (`Host0`, `Host1`), 1-bit enum.
  - `HostIdW` constant.
  - Helper function computing the count width from `MaxOutstanding`.
- Sub-module `tlul_host_arb_id_fifo`: synchronous FIFO of `host_id_e`, depth `MaxOutstanding`, with outputs `full`, `empty` and `head`.
- Top level: grant/lock logic, A mux, D demux, error flag.

## Test plan
- **Single host.** Host 0 issues reads to 0x0 and 0x4, device responds in order → both D beats reach host 0 only. Host 1 `d_valid` stays 0.
- **Contention.** Both hosts hold `a_valid` for 4 handshakes with device `a_ready` = 1 → grant order h0, h1, h0, h1. With the macro defined: h1, h1, h1, h1.
- **Lock.** Host 0 is presented with device `a_ready` = 0 for 3 cycles while host 1 also asserts `a_valid` → `tl_d_o` holds host 0's address and data unchanged until accept. Host 1 is granted the next cycle.
- **Full.** `MaxOutstanding` = 2, two accepted requests with no response → third `a_valid` is not forwarded. After one D handshake it is accepted the next cycle.
- **Error.** Device `d_valid` asserted with FIFO empty → `d_ready` = 1, neither host sees `d_valid`, `arb_err_o` = 1 until reset.
- **Reset.** Assert `rst_ni` = 0 with 2 outstanding → FIFO empties and all outputs return to reset values. A following D beat sets `arb_err_o`.

Source files
------------

// File: rtl/tlul_host_arb_pkg.sv
// Shared types for the two-host TL-UL arbiter: TL-UL channel structs, host IDs,
// lock state encoding and width helpers for the response-routing ID FIFO.
package tlul_host_arb_pkg;

  localparam int unsigned AddrW   = 32;
  localparam int unsigned DataW   = 32;
  localparam int unsigned MaskW   = DataW / 8;
  localparam int unsigned SourceW = 8;
  localparam int unsigned HostIdW = 1;

  typedef enum logic [HostIdW-1:0] {
    Host0 = 1'b0,
    Host1 = 1'b1
  } host_id_e;

  typedef enum logic {
    LockIdle = 1'b0,
    LockHeld = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic               a_valid;
    logic [2:0]         a_opcode;
    logic [2:0]         a_param;
    logic [1:0]         a_size;
    logic [SourceW-1:0] a_source;
    logic [AddrW-1:0]   a_address;
    logic [MaskW-1:0]   a_mask;
    logic [DataW-1:0]   a_data;
    logic               d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic               d_valid;
    logic [2:0]         d_opcode;
    logic [2:0]         d_param;
    logic [1:0]         d_size;
    logic [SourceW-1:0] d_source;
    logic               d_sink;
    logic [DataW-1:0]   d_data;
    logic               d_error;
    logic               a_ready;
  } tl_d2h_t;

  // Count must represent 0..depth inclusive, hence depth + 1 states.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tlul_host_arb_id_fifo.sv
// In-order FIFO of host IDs, one entry per accepted A request, whose head tells
// the arbiter which host owns the next D beat.
module tlul_host_arb_id_fifo
  import tlul_host_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  host_id_e wdata_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output host_id_e head_o
);

  localparam int unsigned CntW = cnt_width(Depth);
  localparam int unsigned PtrW = ptr_width(Depth);

  host_id_e        mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push;
  logic            do_pop;

  // Full is taken from the registered count only, so a same-cycle pop never
  // opens room for a push.
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= Host0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/tlul_host_arb2.sv
// Two-host TL-UL arbiter: round-robin (or fixed host-1 priority when
// TLUL_HOST_ARB_FIXED_PRIO_EN is defined) request-locking grant, ID-FIFO D routing.
module tlul_host_arb2
  import tlul_host_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h0_i,
  output tl_d2h_t tl_h0_o,
  input  tl_h2d_t tl_h1_i,
  output tl_d2h_t tl_h1_o,
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i,
  output logic    arb_err_o
);

  lock_state_e lock_q, lock_d;
  host_id_e    lock_host_q, lock_host_d;
  host_id_e    last_grant_q, last_grant_d;
  host_id_e    sel;
  tl_h2d_t     sel_req;
  logic        sel_valid;
  logic        a_hs;
  logic        fifo_full;
  logic        fifo_empty;
  host_id_e    fifo_head;
  logic        route_valid;
  logic        target_d_ready;
  logic        d_hs;
  logic        err_q, err_d;

  // Device a_ready never feeds selection directly; it only acts via the lock.
  always_comb begin
    sel = Host0;
    if (lock_q == LockHeld) begin
      sel = lock_host_q;
    end else if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
      sel = Host1;
`else
      sel = (last_grant_q == Host0) ? Host1 : Host0;
`endif
    end else if (tl_h1_i.a_valid) begin
      sel = Host1;
    end
  end

  assign sel_req   = (sel == Host1) ? tl_h1_i : tl_h0_i;
  assign sel_valid = sel_req.a_valid;
  assign a_hs      = sel_valid && !fifo_full && tl_d_i.a_ready;

  // A presented-but-unaccepted request keeps the grant until it is taken.
  always_comb begin
    lock_d       = lock_q;
    lock_host_d  = lock_host_q;
    last_grant_d = last_grant_q;
    unique case (lock_q)
      LockIdle: begin
        if (sel_valid && !a_hs) begin
          lock_d      = LockHeld;
          lock_host_d = sel;
        end
      end
      LockHeld: begin
        if (a_hs || !sel_valid) begin
          lock_d = LockIdle;
        end
      end
      default: lock_d = LockIdle;
    endcase
    if (a_hs) begin
      last_grant_d = sel;
    end
  end

  assign route_valid    = tl_d_i.d_valid && !fifo_empty;
  assign target_d_ready = (fifo_head == Host1) ? tl_h1_i.d_ready : tl_h0_i.d_ready;
  assign d_hs           = route_valid && target_d_ready;
  assign err_d          = err_q || (tl_d_i.d_valid && fifo_empty);

  always_comb begin
    tl_d_o         = sel_req;
    tl_d_o.a_valid = sel_valid && !fifo_full;
    tl_d_o.d_ready = fifo_empty ? 1'b1 : target_d_ready;
  end

  always_comb begin
    tl_h0_o         = tl_d_i;
    tl_h0_o.d_valid = route_valid && (fifo_head == Host0);
    tl_h0_o.a_ready = (sel == Host0) && tl_d_i.a_ready && !fifo_full;
  end

  always_comb begin
    tl_h1_o         = tl_d_i;
    tl_h1_o.d_valid = route_valid && (fifo_head == Host1);
    tl_h1_o.a_ready = (sel == Host1) && tl_d_i.a_ready && !fifo_full;
  end

  assign arb_err_o = err_q;

  tlul_host_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (a_hs),
    .wdata_i (sel),
    .pop_i   (d_hs),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Reset value Host1 lets host 0 win the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= LockIdle;
      lock_host_q  <= Host0;
      last_grant_q <= Host1;
      err_q        <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_host_q  <= lock_host_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_tlul_host_arb2.sv
// Randomized scoreboard bench for tlul_host_arb2: a grant/ordering model checked
// every cycle, followed by directed full, error and reset sequences.
module tb_tlul_host_arb2;
  import tlul_host_arb_pkg::*;

  localparam int MaxOut     = 2;
  localparam int RandCycles = 3000;

  logic    clk = 1'b0;
  logic    rst_n;
  tl_h2d_t h0In, h1In, devReq;
  tl_d2h_t h0Out, h1Out, devRsp;
  logic    arbErr;

  always #5 clk = ~clk;

  tlul_host_arb2 #(.MaxOutstanding(MaxOut)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .tl_h0_i   (h0In),
    .tl_h0_o   (h0Out),
    .tl_h1_i   (h1In),
    .tl_h1_o   (h1Out),
    .tl_d_o    (devReq),
    .tl_d_i    (devRsp),
    .arb_err_o (arbErr)
  );

  typedef struct {int host; logic [31:0] data;} exp_t;
  typedef struct {logic [31:0] addr; logic [7:0] src;} dev_t;

  exp_t idQ[$];
  dev_t devQ[$];
  int   nChecks = 0;
  int   nPass   = 0;
  int   lockHost = -1;
  int   lastWin  = 1;
  bit   errModel = 1'b0;
  bit   monEn    = 1'b0;
  bit   genReq   = 1'b0;
  bit   aAcc0 = 1'b0, aAcc1 = 1'b0, dAcc = 1'b0;

  function automatic logic [31:0] respData(logic [31:0] a, logic [7:0] s);
    return a ^ 32'h5A5A_0000 ^ {24'h0, s};
  endfunction

  function automatic tl_h2d_t newReq();
    tl_h2d_t r;
    r           = '0;
    r.a_valid   = 1'b1;
    r.a_opcode  = ($urandom_range(0, 1) == 1) ? 3'h4 : 3'h0;
    r.a_size    = 2'd2;
    r.a_source  = 8'($urandom_range(0, 255));
    r.a_address = $urandom & 32'hFFFF_FFFC;
    r.a_mask    = 4'hF;
    r.a_data    = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model evaluated once per cycle, mid-cycle, from the arbitration rules.
  task automatic monitorCycle();
    bit full;
    bit expRdy;
    int ew;
    int t;
    logic tgtReady;
    full = (idQ.size() >= MaxOut);
    checkOutput("arb_err", 32'(arbErr), 32'(errModel));
    if (devRsp.d_valid) begin
      if (idQ.size() == 0) begin
        checkOutput("drop_d_ready", 32'(devReq.d_ready), 32'd1);
        checkOutput("drop_h0_d_valid", 32'(h0Out.d_valid), 32'd0);
        checkOutput("drop_h1_d_valid", 32'(h1Out.d_valid), 32'd0);
        errModel = 1'b1;
      end else begin
        t = idQ[0].host;
        tgtReady = (t == 1) ? h1In.d_ready : h0In.d_ready;
        checkOutput("d_route_h0", 32'(h0Out.d_valid), 32'(t == 0));
        checkOutput("d_route_h1", 32'(h1Out.d_valid), 32'(t == 1));
        checkOutput("d_data", (t == 1) ? h1Out.d_data : h0Out.d_data, idQ[0].data);
        checkOutput("d_ready", 32'(devReq.d_ready), 32'(tgtReady));
        if (tgtReady) begin
          idQ.delete(0);
          dAcc = 1'b1;
        end
      end
    end else begin
      checkOutput("idle_h0_d_valid", 32'(h0Out.d_valid), 32'd0);
      checkOutput("idle_h1_d_valid", 32'(h1Out.d_valid), 32'd0);
    end
    if (h0In.a_valid || h1In.a_valid) begin
      if (lockHost >= 0) ew = lockHost;
      else if (h0In.a_valid && h1In.a_valid) begin
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
        ew = 1;
`else
        ew = (lastWin == 0) ? 1 : 0;
`endif
      end else ew = h1In.a_valid ? 1 : 0;
      checkOutput("a_valid", 32'(devReq.a_valid), 32'(!full));
      checkOutput("a_address", devReq.a_address, (ew == 1) ? h1In.a_address : h0In.a_address);
      checkOutput("a_data", devReq.a_data, (ew == 1) ? h1In.a_data : h0In.a_data);
      expRdy = devRsp.a_ready && !full;
      checkOutput("a_ready_h0", 32'(h0Out.a_ready), 32'(expRdy && ew == 0));
      checkOutput("a_ready_h1", 32'(h1Out.a_ready), 32'(expRdy && ew == 1));
      if (expRdy) begin
        exp_t e;
        dev_t d;
        lastWin  = ew;
        lockHost = -1;
        d.addr   = (ew == 1) ? h1In.a_address : h0In.a_address;
        d.src    = (ew == 1) ? h1In.a_source : h0In.a_source;
        e.host   = ew;
        e.data   = respData(d.addr, d.src);
        idQ.push_back(e);
        devQ.push_back(d);
        if (ew == 1) aAcc1 = 1'b1;
        else aAcc0 = 1'b1;
      end else begin
        lockHost = ew;
      end
    end else begin
      checkOutput("a_idle", 32'(devReq.a_valid), 32'd0);
      lockHost = -1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (monEn) monitorCycle();
    end
  end

  // Hosts hold a request until accepted; the device responds in order.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (aAcc0) begin aAcc0 = 1'b0; h0In.a_valid = 1'b0; end
    if (aAcc1) begin aAcc1 = 1'b0; h1In.a_valid = 1'b0; end
    if (!h0In.a_valid && genReq && $urandom_range(0, 2) != 0) h0In = newReq();
    if (!h1In.a_valid && genReq && $urandom_range(0, 2) != 0) h1In = newReq();
    h0In.d_ready = ($urandom_range(0, 3) != 0);
    h1In.d_ready = ($urandom_range(0, 3) != 0);
    if (dAcc) begin
      dAcc = 1'b0;
      devQ.delete(0);
      devRsp.d_valid = 1'b0;
    end
    if (!devRsp.d_valid && devQ.size() > 0 && $urandom_range(0, 2) == 0) begin
      devRsp.d_valid  = 1'b1;
      devRsp.d_opcode = 3'h1;
      devRsp.d_source = devQ[0].src;
      devRsp.d_data   = respData(devQ[0].addr, devQ[0].src);
    end
    devRsp.a_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    h0In   = '0;
    h1In   = '0;
    devRsp = '0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_err", 32'(arbErr), 32'd0);
    checkOutput("reset_a_valid", 32'(devReq.a_valid), 32'd0);
    checkOutput("reset_h0_d_valid", 32'(h0Out.d_valid), 32'd0);
    checkOutput("reset_h1_d_valid", 32'(h1Out.d_valid), 32'd0);
    checkOutput("reset_d_ready", 32'(devReq.d_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    monEn  = 1'b1;
    genReq = 1'b1;
    repeat (RandCycles) applyStimulus();
    genReq = 1'b0;
    for (int i = 0; i < 500 && (devQ.size() > 0 || h0In.a_valid || h1In.a_valid || devRsp.d_valid); i++)
      applyStimulus();
    checkOutput("drained", 32'(devQ.size() + idQ.size()), 32'd0);
    monEn = 1'b0;

    // Unexpected D beat with nothing outstanding.
    h0In = '0;
    h1In = '0;
    devRsp.d_valid = 1'b1;
    devRsp.d_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("err_d_ready", 32'(devReq.d_ready), 32'd1);
    checkOutput("err_h0_d_valid", 32'(h0Out.d_valid), 32'd0);
    checkOutput("err_h1_d_valid", 32'(h1Out.d_valid), 32'd0);
    checkOutput("err_before_edge", 32'(arbErr), 32'd0);
    @(posedge clk);
    #1;
    devRsp.d_valid = 1'b0;
    checkOutput("err_set", 32'(arbErr), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("err_sticky", 32'(arbErr), 32'd1);

    // Fill to MaxOut, show the next request held off until after a D handshake.
    devRsp.a_ready = 1'b1;
    h0In = newReq();
    h0In.d_ready = 1'b1;
    @(posedge clk);
    #1;
    h0In = newReq();
    h0In.d_ready = 1'b1;
    @(posedge clk);
    #1;
    h0In.a_valid = 1'b0;
    h1In = newReq();
    h1In.d_ready = 1'b1;
    @(negedge clk);
    checkOutput("full_a_valid", 32'(devReq.a_valid), 32'd0);
    checkOutput("full_h1_a_ready", 32'(h1Out.a_ready), 32'd0);
    @(posedge clk);
    #1;
    devRsp.d_valid = 1'b1;
    @(negedge clk);
    checkOutput("pop_cycle_a_valid", 32'(devReq.a_valid), 32'd0);
    checkOutput("pop_cycle_h0_d_valid", 32'(h0Out.d_valid), 32'd1);
    @(posedge clk);
    #1;
    devRsp.d_valid = 1'b0;
    @(negedge clk);
    checkOutput("after_pop_a_valid", 32'(devReq.a_valid), 32'd1);
    checkOutput("after_pop_h1_a_ready", 32'(h1Out.a_ready), 32'd1);
    checkOutput("after_pop_a_address", devReq.a_address, h1In.a_address);
    @(posedge clk);
    #1;
    h1In.a_valid = 1'b0;

    // Reset with two outstanding, then a stale response.
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_err", 32'(arbErr), 32'd0);
    checkOutput("midreset_a_valid", 32'(devReq.a_valid), 32'd0);
    checkOutput("midreset_d_ready", 32'(devReq.d_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    devRsp.d_valid = 1'b1;
    #1;
    checkOutput("stale_h0_d_valid", 32'(h0Out.d_valid), 32'd0);
    checkOutput("stale_h1_d_valid", 32'(h1Out.d_valid), 32'd0);
    @(posedge clk);
    #1;
    devRsp.d_valid = 1'b0;
    checkOutput("stale_err", 32'(arbErr), 32'd1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
